// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, 33-cycle latency,
// low 32 product bits plus a signed-overflow flag.
module mult_booth (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam int unsigned W  = 32;
  localparam int unsigned AW = W + 1;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_m;
  logic [AW-1:0]   r_acc;
  logic [W-1:0]    r_q;
  logic            r_q_m1;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;
  logic            r_exc;
  logic            r_rdy;

  logic [AW-1:0]   w_acc_sum;
  logic [AW-1:0]   w_acc_sh;
  logic [W-1:0]    w_q_sh;
  logic            w_q_m1_sh;
  logic [AW-1:0]   w_p_hi;
  logic            w_last;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; a start strobe overrides everything, including an in-flight run
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = IDLE;
      RUN: begin
        if (r_cnt == CW'(W - 1)) begin
          w_state_nxt = DONE;
          w_last      = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (ctrl_MULT) begin
      w_state_nxt = RUN;
      w_last      = 1'b0;
    end
  end

  // Booth add/subtract, then arithmetic shift of {ACC,Q,Q_-1}
  always_comb begin
    case ({r_q[0], r_q_m1})
      2'b01:   w_acc_sum = r_acc + r_m;
      2'b10:   w_acc_sum = r_acc - r_m;
      default: w_acc_sum = r_acc;
    endcase
    w_acc_sh  = {w_acc_sum[AW-1], w_acc_sum[AW-1:1]};
    w_q_sh    = {w_acc_sum[0], r_q[W-1:1]};
    w_q_m1_sh = r_q[0];
    w_p_hi    = {w_acc_sh[W-1:0], w_q_sh[W-1]};
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_q_m1   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else if (ctrl_MULT) begin
      r_m    <= {data_operandA[W-1], data_operandA};
      r_acc  <= '0;
      r_q    <= data_operandB;
      r_q_m1 <= 1'b0;
      r_cnt  <= '0;
      r_rdy  <= 1'b0;
    end else begin
      r_rdy <= w_last;
      if (r_state == RUN) begin
        r_acc  <= w_acc_sh;
        r_q    <= w_q_sh;
        r_q_m1 <= w_q_m1_sh;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_last) begin
        r_result <= w_q_sh;
        r_exc    <= ~((&w_p_hi) | ~(|w_p_hi));
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_mult_booth.sv
// Directed bench for mult_booth: product table, latency, abort and reset-mid-run sequences.
module tb_mult_booth;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[14];

  mult_booth dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then scramble operands to prove they are ignored
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Edges after the start edge until data_resultRDY is seen (bounded)
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc);
    int lat;
    start(a, b);
    wait_rdy(lat);
    chk({name, " latency"}, 32'(lat), 32'd32);
    chk({name, " result"}, data_result, res);
    chk({name, " exception"}, 32'(data_exception), 32'(exc));
    @(negedge clock);
    chk({name, " rdy pulse width"}, 32'(data_resultRDY), 32'd0);
    chk({name, " result held"}, data_result, res);
  endtask

  initial begin
    int lat;
    int pulses;
    vecs[0]  = '{32'd3,          32'd5,          32'h0000000F, 1'b0};
    vecs[1]  = '{-32'sd7,        32'd6,          32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{32'h80000000,   32'd1,          32'h80000000, 1'b0};
    vecs[3]  = '{32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1};
    vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1};
    vecs[5]  = '{32'h80000000,   32'h80000000,   32'h00000000, 1'b1};
    vecs[6]  = '{32'h00010000,   32'h00010000,   32'h00000000, 1'b1};
    vecs[7]  = '{32'd0,          32'hFFFFFFFF,   32'h00000000, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0};
    vecs[9]  = '{32'h7FFFFFFF,   32'h7FFFFFFF,   32'h00000001, 1'b1};
    vecs[10] = '{32'hFFFFFFFF,   32'h80000000,   32'h80000000, 1'b1};
    vecs[11] = '{32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000001, 1'b0};
    vecs[12] = '{32'h80000000,   32'd0,          32'h00000000, 1'b0};
    vecs[13] = '{32'd12345,      -32'sd100,      32'hFFED29BC, 1'b0};

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset result", data_result, 32'd0);
    chk("reset exception", 32'(data_exception), 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);

    // Abort at iteration 10 with new operands: only the second op completes
    run_vec("pre-abort", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
    start(32'd3, 32'd5);
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("result stable during run", data_result, 32'hFFFFFFFE);
    start(32'd4, 32'd4);
    chk("abort no early pulse", 32'(pulses), 32'd0);
    wait_rdy(lat);
    chk("abort latency", 32'(lat), 32'd32);
    chk("abort result", data_result, 32'h00000010);
    chk("abort exception", 32'(data_exception), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("abort single pulse", 32'(pulses), 32'd0);

    // Reset at iteration 20 clears everything and suppresses the pulse
    run_vec("pre-reset", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
    start(32'd3, 32'd5);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrun reset result", data_result, 32'd0);
    chk("midrun reset exception", 32'(data_exception), 32'd0);
    chk("midrun reset rdy", 32'(data_resultRDY), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("midrun reset no pulse", 32'(pulses), 32'd0);
    run_vec("post-reset", -32'sd7, 32'd6, 32'hFFFFFFD6, 1'b0);

    // Reset wins over a simultaneous start
    @(negedge clock);
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    @(negedge clock);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    wait_rdy(lat);
    chk("reset priority no result", 32'(lat), 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
